mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I core, directly downstream of the execute-stage ALU. Takes the ALU result as an effective address (loads and stores) or as a pass-through result (all other ops). Drives a single-outstanding request/acknowledge data-memory port with byte-lane alignment and load sign/zero extension. Presents a one-cycle-valid writeback record to the register-file stage.

## Interface
- `ACK_TIMEOUT`, default 16: maximum number of cycles `dmem_req` may stay high without `dmem_ack`; expiry raises a bus error. Range 2..255.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: execute stage presents an op.
- `ex_ready` out 1: stage can accept; transfer occurs when `ex_valid && ex_ready`.
- `ex_result` in 32: ALU result (effective address for loads/stores).
- `ex_store_data` in 32: rs2 value for stores.
- `ex_funct3` in 3: RISC-V load/store funct3.
- `ex_is_load`, `ex_is_store` in 1 each: op class, mutually exclusive.
- `ex_rd` in 5: destination register.
- `ex_reg_write` in 1: op writes rd.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address, bits [1:0] = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: request completed; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle pulse per retired op.
- `wb_rd` out 5; `wb_we` out 1; `wb_data` out 32: writeback record.
- `exc_valid` out 1: one-cycle pulse for a faulting op, coincident with `wb_valid`.
- `exc_cause` out 2: 0 = misaligned, 1 = illegal funct3, 2 = bus timeout.

## Operation
- FSM states:
  - IDLE: `ex_ready` = 1.
  - REQ: request outstanding; `ex_ready` = 0.
  - RESP: retire pulse; `ex_ready` = 0.
- **Non-memory op accepted in IDLE:** the next cycle shows `wb_valid`=1, `wb_data`=ex_result, `wb_we`=ex_reg_write. FSM stays in IDLE, so back-to-back ALU ops retire one per cycle.
- **Load/store accepted in IDLE:** address, lanes and data are registered, then the FSM goes to REQ.
  - Lane selection by funct3[1:0] and addr[1:0]:
    - byte: `be` = 1 << addr[1:0].
    - half: `be` = 0011 or 1100 by addr[1].
    - word: `be` = 1111.
  - Store data is replicated: byte ×4, half ×2.
- **Load extraction:** select the lane from `dmem_rdata`. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value faults with cause 1, with no request and `wb_we`=0.
- **Faulting ops** retire through RESP with `exc_valid`=1, `wb_we`=0 and `wb_data`=0.
- **Stores** retire with `wb_we`=0.

## Timing
- **Reset values:** FSM IDLE, `ex_ready`=1. `dmem_req`, `dmem_we`, `wb_valid`, `wb_we` and `exc_valid` are 0. `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_rd`, `wb_data` and `exc_cause` are 0.
- **Request start:** `dmem_req` rises the cycle after acceptance. Address, be, we and wdata stay stable while `dmem_req`=1.
- **Acknowledge:** `dmem_ack` is sampled only in REQ. On ack, `dmem_req` drops the next cycle and the FSM enters RESP. `wb_valid` pulses in RESP, and the FSM returns to IDLE the following cycle.
- **Latency:** minimum 3 cycles from acceptance to `wb_valid` (acceptance, REQ with same-cycle ack, RESP).
- **Timeout:** an internal counter resets on entry to REQ. If it reaches ACK_TIMEOUT with no ack, `dmem_req` drops and RESP retires with cause 2. An ack arriving in that same cycle wins and no fault is raised.
- **Spurious ack:** `dmem_ack` is ignored outside REQ.
- **Reset mid-request:** `dmem_req` clears immediately (async). No `wb_valid` is produced for the aborted op.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, faults with cause 0.
  - No `dmem_req` is issued; the op retires with `exc_valid`=1 two cycles after acceptance.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are forced to natural alignment (half clears addr[0]; word clears addr[1:0]).
  - The access proceeds normally; cause 0 is never produced.

## Test plan
- ALU op, ex_result=0x1234, rd=5, reg_write=1, then a second op the next cycle -> `wb_valid` on consecutive cycles; the first record is `wb_data`=0x1234, `wb_rd`=5.
- LB at addr 0x103, rdata=0x80FF_FF7F with same-cycle ack -> `dmem_addr`=0x100, `be`=1000, `wb_data`=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH at addr 0x202, store_data=0xABCD_1234 -> `be`=1100, `wdata`=0x1234_1234, `we`=1, `wb_we`=0.
- LW at 0x10 with `dmem_ack` withheld -> `dmem_req` held for ACK_TIMEOUT cycles, then `exc_valid`=1, cause=2, `ex_ready` back to 1.
- LW at 0x12:
  - With `MEM_MISALIGN_TRAP_EN` -> no `dmem_req`, cause=0.
  - Without it -> `dmem_addr`=0x10, `be`=1111.
- Load funct3=011 -> cause=1 with no request. Separately, assert `rst_n` low while in REQ -> `dmem_req`=0 at once and no `wb_valid`.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage driving a single-outstanding req/ack data port.
// Optional `MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic accept, is_mem, f3_ok, mis, fault, timeout, done;
  logic [1:0] off, off_q, cause_q;
  logic [3:0] be;
  logic [31:0] wdata, lane, ld_data;
  logic [2:0] f3_q;
  logic ld_q, rw_q, fault_q;
  assign ex_ready = state == IDLE;
  assign accept = ex_valid && ex_ready;
  assign is_mem = ex_is_load || ex_is_store;
  assign f3_ok = ex_is_load ? (ex_funct3 != 3'b011 && ex_funct3[2:1] != 2'b11)
                            : (!ex_funct3[2] && ex_funct3[1:0] != 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (ex_funct3[1:0] == 2'b01 && ex_result[0]) ||
               (ex_funct3[1:0] == 2'b10 && ex_result[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign fault = !f3_ok || mis;
  // Byte offset after natural alignment; only differs from addr[1:0] when alignment is forced
  assign off = ex_funct3[1:0] == 2'b00 ? ex_result[1:0] :
               ex_funct3[1:0] == 2'b01 ? {ex_result[1], 1'b0} : 2'b00;
  assign be = ex_funct3[1:0] == 2'b00 ? 4'b0001 << off :
              ex_funct3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = ex_funct3[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
                 ex_funct3[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
  assign lane = dmem_rdata >> {off_q, 3'b000};
  assign ld_data = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && lane[7]}}, lane[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && lane[15]}}, lane[15:0]} : lane;
  // Faulting ops pass one cycle through REQ with no request so they retire on the load timeline
  assign timeout = !fault_q && !dmem_ack && cnt == 8'(ACK_TIMEOUT - 1);
  assign done = fault_q || dmem_ack || timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && is_mem) state_nx = REQ;
      REQ: if (done) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_we <= 1'b0;
      wb_data <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      cnt <= '0;
      off_q <= '0;
      f3_q <= '0;
      ld_q <= 1'b0;
      rw_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= '0;
    end else begin
      wb_valid <= 1'b0;
      exc_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid <= 1'b1;
        wb_rd <= ex_rd;
        wb_we <= ex_reg_write;
        wb_data <= ex_result;
      end
      if (accept && is_mem) begin
        dmem_req <= !fault;
        dmem_we <= ex_is_store && !fault;
        dmem_addr <= {ex_result[31:2], 2'b00};
        dmem_be <= be;
        dmem_wdata <= wdata;
        off_q <= off;
        f3_q <= ex_funct3;
        ld_q <= ex_is_load;
        rw_q <= ex_reg_write;
        wb_rd <= ex_rd;
        fault_q <= fault;
        cause_q <= f3_ok ? 2'd0 : 2'd1;
        cnt <= '0;
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
        if (done) begin
          dmem_req <= 1'b0;
          dmem_we <= 1'b0;
          wb_valid <= 1'b1;
          exc_valid <= fault_q || timeout;
          wb_we <= ld_q && rw_q && !fault_q && !timeout;
          wb_data <= (ld_q && !fault_q && !timeout) ? ld_data : 32'd0;
          if (fault_q || timeout) exc_cause <= fault_q ? cause_q : 2'd2;
        end
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage ALU pass-through, loads/stores, faults, timeout and reset.
module tb_mem_stage;
  localparam int TO = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid = 1'b0, ex_ready, ex_is_load = 1'b0, ex_is_store = 1'b0, ex_reg_write = 1'b0;
  logic [31:0] ex_result = '0, ex_store_data = '0, dmem_addr, dmem_wdata, dmem_rdata = '0, wb_data;
  logic [2:0] ex_funct3 = '0;
  logic [4:0] ex_rd = '0, wb_rd;
  logic dmem_req, dmem_we, dmem_ack = 1'b0, wb_valid, wb_we, exc_valid;
  logic [3:0] dmem_be;
  logic [1:0] exc_cause;
  int checks = 0, failures = 0, n;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one memory op for one cycle; returns at the negedge of the first cycle after acceptance
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_result = a; ex_store_data = sd; ex_rd = 5'd7; ex_reg_write = ld;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_cause", exc_cause, 0);
    @(negedge clk); rst_n = 1'b1;
    // Back-to-back ALU ops
    @(negedge clk);
    ex_valid = 1'b1; ex_result = 32'h1234; ex_rd = 5'd5; ex_reg_write = 1'b1;
    @(negedge clk);
    chk("alu1_valid", wb_valid, 1);
    chk("alu1_data", wb_data, 32'h1234);
    chk("alu1_rd", wb_rd, 5);
    chk("alu1_we", wb_we, 1);
    ex_result = 32'h55; ex_rd = 5'd6; ex_reg_write = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("alu2_valid", wb_valid, 1);
    chk("alu2_data", wb_data, 32'h55);
    chk("alu2_we", wb_we, 0);
    @(negedge clk);
    chk("alu_idle_wbv", wb_valid, 0);
    // LB at 0x103, same-cycle ack
    mem_op(1, 0, 3'b000, 32'h103, 0);
    chk("lb_req", dmem_req, 1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", dmem_be, 4'b1000);
    chk("lb_we", dmem_we, 0);
    chk("lb_ready", ex_ready, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    @(negedge clk); dmem_ack = 1'b0;
    chk("lb_req_drop", dmem_req, 0);
    chk("lb_wbv", wb_valid, 1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wbwe", wb_we, 1);
    chk("lb_rd", wb_rd, 7);
    chk("lb_exc", exc_valid, 0);
    @(negedge clk);
    chk("lb_back_idle", ex_ready, 1);
    chk("lb_wbv_clear", wb_valid, 0);
    // LBU at 0x103
    mem_op(1, 0, 3'b100, 32'h103, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    @(negedge clk); dmem_ack = 1'b0;
    chk("lbu_data", wb_data, 32'h0000_0080);
    // LH at 0x106 sign-extends upper half
    mem_op(1, 0, 3'b001, 32'h106, 0);
    chk("lh_be", dmem_be, 4'b1100);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_7FFF;
    @(negedge clk); dmem_ack = 1'b0;
    chk("lh_data", wb_data, 32'hFFFF_8001);
    // SH at 0x202, ack withheld one cycle
    mem_op(0, 1, 3'b001, 32'h202, 32'hABCD_1234);
    chk("sh_req", dmem_req, 1);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_we", dmem_we, 1);
    @(negedge clk);
    chk("sh_req_hold", dmem_req, 1);
    chk("sh_addr_hold", dmem_addr, 32'h200);
    chk("sh_wbv_early", wb_valid, 0);
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("sh_wbv", wb_valid, 1);
    chk("sh_wbwe", wb_we, 0);
    chk("sh_exc", exc_valid, 0);
    // SB at 0x41
    mem_op(0, 1, 3'b000, 32'h41, 32'h0000_00A5);
    chk("sb_be", dmem_be, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("sb_wbv", wb_valid, 1);
    // LW at 0x10 with no ack: timeout
    mem_op(1, 0, 3'b010, 32'h10, 0);
    n = 0;
    while (dmem_req && n < 100) begin n++; @(negedge clk); end
    chk("to_req_cycles", n, TO);
    chk("to_wbv", wb_valid, 1);
    chk("to_exc", exc_valid, 1);
    chk("to_cause", exc_cause, 2);
    chk("to_wbwe", wb_we, 0);
    chk("to_wbdata", wb_data, 0);
    @(negedge clk);
    chk("to_ready", ex_ready, 1);
    // Ack in the timeout cycle wins
    mem_op(1, 0, 3'b010, 32'h14, 0);
    repeat (TO - 1) @(negedge clk);
    chk("tow_req", dmem_req, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk); dmem_ack = 1'b0;
    chk("tow_exc", exc_valid, 0);
    chk("tow_data", wb_data, 32'hCAFE_F00D);
    chk("tow_wbwe", wb_we, 1);
    // LW at 0x12
    mem_op(1, 0, 3'b010, 32'h12, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_noreq", dmem_req, 0);
    @(negedge clk);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_exc", exc_valid, 1);
    chk("mis_cause", exc_cause, 0);
    chk("mis_wbwe", wb_we, 0);
`else
    chk("mis_req", dmem_req, 1);
    chk("mis_addr", dmem_addr, 32'h10);
    chk("mis_be", dmem_be, 4'b1111);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); dmem_ack = 1'b0;
    chk("mis_data", wb_data, 32'hDEAD_BEEF);
    chk("mis_exc", exc_valid, 0);
`endif
    // Illegal load funct3
    mem_op(1, 0, 3'b011, 32'h20, 0);
    chk("ill_noreq", dmem_req, 0);
    @(negedge clk);
    chk("ill_wbv", wb_valid, 1);
    chk("ill_exc", exc_valid, 1);
    chk("ill_cause", exc_cause, 1);
    chk("ill_wbwe", wb_we, 0);
    // Illegal store funct3
    mem_op(0, 1, 3'b100, 32'h24, 0);
    chk("ills_noreq", dmem_req, 0);
    @(negedge clk);
    chk("ills_cause", exc_cause, 1);
    chk("ills_exc", exc_valid, 1);
    // Spurious ack in IDLE
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("spur_wbv", wb_valid, 0);
    chk("spur_ready", ex_ready, 1);
    // Reset during REQ
    mem_op(1, 0, 3'b010, 32'h30, 0);
    chk("rreq_req", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq_req_clr", dmem_req, 0);
    chk("rreq_ready", ex_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rreq_wbv1", wb_valid, 0);
    @(negedge clk);
    chk("rreq_wbv2", wb_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
